// File: rtl/sonic_eth_10g_tx_pause_frame_inserter.sv
// 10G MAC TX stage: forwards client Avalon-ST packets untouched and slots an
// 802.3x PAUSE frame (60 bytes, FCS added downstream) in at packet boundaries.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | between packets; client passes through unless a frame is owed
// ST_PASS  | inside a client packet; requests are only latched
// ST_PAUSE | emitting the PAUSE frame, bcnt selects beat 0..7
module sonic_eth_10g_tx_pause_frame_inserter #(
  parameter logic [47:0] SRC_MAC  = 48'h000000000000,
  parameter logic [47:0] PAUSE_DA = 48'h0180C2000001
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        in_ready,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  input  logic        in_error,
  input  logic        in_startofpacket,
  input  logic        in_endofpacket,
  input  logic [2:0]  in_empty,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [63:0] out_data,
  output logic        out_error,
  output logic        out_startofpacket,
  output logic        out_endofpacket,
  output logic [2:0]  out_empty,
  input  logic        pause_req,
  input  logic [15:0] pause_quanta,
  output logic        pause_pending,
  output logic        pause_sent
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic        pending_q, pending_d;
  logic [15:0] quanta_q, quanta_d;
  logic [15:0] frame_quanta_q, frame_quanta_d;
  logic        pause_sent_q, pause_sent_d;

  logic        in_acc;
  logic        pass_en;

  assign pause_pending = pending_q;
  assign pause_sent    = pause_sent_q;

  // Output mux: client pass-through or PAUSE beat; everything forced low in reset.
  always_comb begin
    in_ready          = 1'b0;
    out_valid         = 1'b0;
    out_data          = 64'h0;
    out_error         = 1'b0;
    out_startofpacket = 1'b0;
    out_endofpacket   = 1'b0;
    out_empty         = 3'd0;
    pass_en           = 1'b0;
    if (reset_n) begin
      case (state_q)
        ST_IDLE:  pass_en = !pending_q;
        ST_PASS:  pass_en = 1'b1;
        default:  pass_en = 1'b0;
      endcase
      if (pass_en) begin
        in_ready          = out_ready;
        out_valid         = in_valid;
        out_data          = in_data;
        out_error         = in_error;
        out_startofpacket = in_startofpacket;
        out_endofpacket   = in_endofpacket;
        out_empty         = in_empty;
      end else if (state_q == ST_PAUSE) begin
        out_valid         = 1'b1;
        out_startofpacket = (bcnt_q == 3'd0);
        out_endofpacket   = (bcnt_q == 3'd7);
        out_empty         = (bcnt_q == 3'd7) ? 3'd4 : 3'd0;
        case (bcnt_q)
          3'd0:    out_data = {PAUSE_DA, SRC_MAC[47:32]};
          3'd1:    out_data = {SRC_MAC[31:0], 16'h8808, 16'h0001};
          3'd2:    out_data = {frame_quanta_q, 48'h0};
          default: out_data = 64'h0;
        endcase
      end
    end
  end

  assign in_acc = in_valid && in_ready;

  // Next-state: request latch, packet tracking and PAUSE beat sequencing.
  always_comb begin
    state_d        = state_q;
    bcnt_d         = bcnt_q;
    pending_d      = pending_q | pause_req;
    quanta_d       = pause_req ? pause_quanta : quanta_q;
    frame_quanta_d = frame_quanta_q;
    pause_sent_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          state_d   = ST_PAUSE;
          bcnt_d    = 3'd0;
          pending_d = 1'b0;
        end else if (in_acc && in_startofpacket && !in_endofpacket) begin
          // SOP wins over a same-cycle request; the frame follows this packet
          state_d = ST_PASS;
        end else if (pause_req) begin
          state_d   = ST_PAUSE;
          bcnt_d    = 3'd0;
          pending_d = 1'b0;
        end
      end
      ST_PASS: begin
        if (in_acc && in_endofpacket) begin
          if (pending_d) begin
            state_d   = ST_PAUSE;
            bcnt_d    = 3'd0;
            pending_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_PAUSE: begin
        // before b0 is taken a new request only refreshes this frame's quanta
        if (pause_req && bcnt_q == 3'd0 && !out_ready) pending_d = pending_q;
        if (out_ready) begin
          if (bcnt_q == 3'd0) frame_quanta_d = quanta_q;
          if (bcnt_q == 3'd7) begin
            pause_sent_d = 1'b1;
            bcnt_d       = 3'd0;
            if (pending_d) begin
              state_d   = ST_PAUSE;
              pending_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bcnt_d = bcnt_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        bcnt_d  = 3'd0;
      end
    endcase
  end

  // Control registers; reset abandons any partial frame or packet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      bcnt_q         <= 3'd0;
      pending_q      <= 1'b0;
      quanta_q       <= 16'h0;
      frame_quanta_q <= 16'h0;
      pause_sent_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      bcnt_q         <= bcnt_d;
      pending_q      <= pending_d;
      quanta_q       <= quanta_d;
      frame_quanta_q <= frame_quanta_d;
      pause_sent_q   <= pause_sent_d;
    end
  end

endmodule
